systolic_feeder: RTL and testbench

Sequencer that drives the input side of the weight-stationary systolic array. On each `start` it reads K weight tiles and activation tiles from two single-port synchronous SRAMs and replays them into the array. Per tile it emits:

- a weight-load phase;
- an activation-stream phase;
- a drain phase, so the array's per-column accumulators fire exactly once per tile.

It sits between the tile buffers and the array; it is the producer of the activation, weight and control streams the array consumes.

---
 rtl/systolic_feeder.sv | 200 ++++++++++++++++++++
 tb/tb_systolic_feeder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Weight/activation sequencer feeding a weight-stationary systolic array.
// Optional busy-cycle counter enabled by defining FEEDER_PERF_CNT_EN.
//
//   state  | meaning
//   IDLE   | waiting for start; sel held at 1
//   LOAD   | ACCU_NUM weight reads, bottom row first
//   STREAM | BN_NUM activation reads
//   DRAIN  | ACCU_NUM+BM_NUM+2 idle cycles so column accumulators fire once
module systolic_feeder #(
    parameter int BM_NUM   = 4,
    parameter int BN_NUM   = 4,
    parameter int ACCU_NUM = 5,
    parameter int BW_ACT   = 8,
    parameter int BW_WET   = 8,
    parameter int ADDR_W   = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [7:0]                   num_tiles,
    input  logic [ADDR_W-1:0]            wet_base,
    input  logic [ADDR_W-1:0]            act_base,
    output logic                         busy,
    output logic                         done,
    output logic                         wet_rd_en,
    output logic [ADDR_W-1:0]            wet_rd_addr,
    input  logic [BM_NUM*BW_WET-1:0]     wet_rd_data,
    output logic                         act_rd_en,
    output logic [ADDR_W-1:0]            act_rd_addr,
    input  logic [ACCU_NUM*BW_ACT-1:0]   act_rd_data,
    output logic [ACCU_NUM*BW_ACT-1:0]   PE_act_in,
    output logic [BM_NUM*BW_WET-1:0]     PE_wet_in,
    output logic                         PE_weight_partial_sel,
    output logic                         PE_clear_acc,
    output logic                         PE_mac_enable,
    output logic [31:0]                  perf_cycles
);

    localparam int DRAIN_N = ACCU_NUM + BM_NUM + 2;
    localparam int PH_MAX  = (ACCU_NUM > BN_NUM) ? ACCU_NUM : BN_NUM;
    localparam int CNT_MAX = (DRAIN_N > PH_MAX) ? DRAIN_N : PH_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               accept;
    logic               tile_adv;
    logic               job_end;

    logic [7:0]         k_q;
    logic [7:0]         k_last_q;
    logic [ADDR_W-1:0]  wet_base_q;
    logic [ADDR_W-1:0]  act_base_q;
    logic [ADDR_W-1:0]  wet_off_q;
    logic [ADDR_W-1:0]  act_off_q;
    logic               ld_q;
    logic               st_q;
    logic               sel_q;
    logic               clr_q;
    logic               done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Phase timer is a down-counter; terminal count (0) ends each phase.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        tile_adv  = 1'b0;
        job_end   = 1'b0;
        wet_rd_en = 1'b0;
        act_rd_en = 1'b0;
        case (state)
            S_IDLE: begin
                // done_q blocks a restart in the same cycle as the done pulse
                if (start && !done_q) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = CNT_W'(ACCU_NUM - 1);
                    accept    = 1'b1;
                end
            end
            S_LOAD: begin
                wet_rd_en = 1'b1;
                if (cnt == '0) begin
                    state_nxt = S_STREAM;
                    cnt_nxt   = CNT_W'(BN_NUM - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_STREAM: begin
                act_rd_en = 1'b1;
                if (cnt == '0) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = CNT_W'(DRAIN_N - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == '0) begin
                    if (k_q == k_last_q) begin
                        state_nxt = S_IDLE;
                        job_end   = 1'b1;
                    end else begin
                        state_nxt = S_LOAD;
                        cnt_nxt   = CNT_W'(ACCU_NUM - 1);
                        tile_adv  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q        <= '0;
            k_last_q   <= '0;
            wet_base_q <= '0;
            act_base_q <= '0;
            wet_off_q  <= '0;
            act_off_q  <= '0;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            sel_q      <= 1'b1;
            clr_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (accept) begin
                k_q        <= '0;
                k_last_q   <= (num_tiles == 8'd0) ? 8'd0 : num_tiles - 8'd1;
                wet_base_q <= wet_base;
                act_base_q <= act_base;
                wet_off_q  <= '0;
                act_off_q  <= '0;
            end else if (tile_adv) begin
                k_q       <= k_q + 8'd1;
                wet_off_q <= wet_off_q + ADDR_W'(ACCU_NUM);
                act_off_q <= act_off_q + ADDR_W'(BN_NUM);
            end
            ld_q   <= (state == S_LOAD);
            st_q   <= (state == S_STREAM);
            sel_q  <= (state == S_LOAD) || (state == S_IDLE);
            clr_q  <= (state == S_LOAD) && (k_q == 8'd0) && (cnt == CNT_W'(ACCU_NUM - 1));
            done_q <= job_end;
        end
    end

    // Counting cnt down from ACCU_NUM-1 reads the bottom weight row first.
    assign wet_rd_addr = wet_rd_en ? (wet_base_q + wet_off_q + ADDR_W'(cnt)) : '0;
    assign act_rd_addr = act_rd_en ? (act_base_q + act_off_q + ADDR_W'(BN_NUM - 1) - ADDR_W'(cnt)) : '0;

    assign busy                  = (state != S_IDLE);
    assign done                  = done_q;
    assign PE_wet_in             = ld_q ? wet_rd_data : '0;
    assign PE_act_in             = st_q ? act_rd_data : '0;
    assign PE_weight_partial_sel = sel_q || (state == S_IDLE);
    assign PE_clear_acc          = clr_q;
    assign PE_mac_enable         = busy || ld_q || st_q;

`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: table-driven jobs, hand sequences
// for reset/restart corners, and randomized jobs against a cycle-index model.
module tb_systolic_feeder;

    localparam int BM   = 4;
    localparam int BN   = 4;
    localparam int ACCU = 5;
    localparam int D    = ACCU + BM + 2;
    localparam int T    = ACCU + BN + D;
    localparam int WW   = BM * 8;
    localparam int AW   = ACCU * 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    num_tiles;
    logic [9:0]    wet_base;
    logic [9:0]    act_base;
    logic          busy;
    logic          done;
    logic          wet_rd_en;
    logic [9:0]    wet_rd_addr;
    logic [WW-1:0] wet_rd_data;
    logic          act_rd_en;
    logic [9:0]    act_rd_addr;
    logic [AW-1:0] act_rd_data;
    logic [AW-1:0] PE_act_in;
    logic [WW-1:0] PE_wet_in;
    logic          PE_weight_partial_sel;
    logic          PE_clear_acc;
    logic          PE_mac_enable;
    logic [31:0]   perf_cycles;

    logic [WW-1:0] wmem [1024];
    logic [AW-1:0] amem [1024];

    int vectors = 0;
    int errors  = 0;
    int cur_n   = 0;

    always #5 clk = ~clk;

    systolic_feeder dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .num_tiles             (num_tiles),
        .wet_base              (wet_base),
        .act_base              (act_base),
        .busy                  (busy),
        .done                  (done),
        .wet_rd_en             (wet_rd_en),
        .wet_rd_addr           (wet_rd_addr),
        .wet_rd_data           (wet_rd_data),
        .act_rd_en             (act_rd_en),
        .act_rd_addr           (act_rd_addr),
        .act_rd_data           (act_rd_data),
        .PE_act_in             (PE_act_in),
        .PE_wet_in             (PE_wet_in),
        .PE_weight_partial_sel (PE_weight_partial_sel),
        .PE_clear_acc          (PE_clear_acc),
        .PE_mac_enable         (PE_mac_enable),
        .perf_cycles           (perf_cycles)
    );

    // single-port synchronous SRAMs: data one cycle after read enable
    always @(posedge clk) begin
        if (wet_rd_en) wet_rd_data <= wmem[wet_rd_addr];
        if (act_rd_en) act_rd_data <= amem[act_rd_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cur_n, act, exp);
        end
    endtask

    function automatic logic [9:0] w_row_addr(input logic [9:0] wb, input int t, input int r);
        return 10'(int'(wb) + t * ACCU + r);
    endfunction

    function automatic logic [9:0] a_vec_addr(input logic [9:0] ab, input int t, input int j);
        return 10'(int'(ab) + t * BN + j);
    endfunction

    function automatic int exp_perf(input int n);
`ifdef FEEDER_PERF_CNT_EN
        return n - 1;
`else
        return 0 * n;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int kin, input logic [9:0] wb, input logic [9:0] ab,
                           input int ig1, input int ig2, input int abort,
                           input int exp_done, input logic [9:0] exp_fw, input logic [9:0] exp_fa);
        int kef, last, done_seen, edges, nmis;
        logic prev_sel;
        int wrow [ACCU][BM];
        longint acc [BN][BM];
        longint gold [BN][BM];
        logic [WW-1:0] wword;
        logic [AW-1:0] aword;
        kef  = (kin == 0) ? 1 : kin;
        last = kef * T;
        for (int j = 0; j < BN; j++)
            for (int m = 0; m < BM; m++) begin
                acc[j][m]  = 0;
                gold[j][m] = 0;
            end
        for (int r = 0; r < ACCU; r++)
            for (int m = 0; m < BM; m++) wrow[r][m] = 0;
        start     = 1'b1;
        num_tiles = kin[7:0];
        wet_base  = wb;
        act_base  = ab;
        step();
        start     = 1'b0;
        prev_sel  = 1'b1;
        edges     = 0;
        done_seen = -1;
        for (int n = 1; n <= last + 1; n++) begin
            int p, t, pm, tm;
            logic bz, pl, ps;
            logic [WW-1:0] e_wet;
            logic [AW-1:0] e_act;
            start = (n == ig1) || (n == ig2);
            if (start) begin
                num_tiles = 8'($urandom);
                wet_base  = 10'($urandom);
                act_base  = 10'($urandom);
            end
            if (abort > 0 && n == abort)     reset = 1'b1;
            if (abort > 0 && n == abort + 1) reset = 1'b0;
            @(negedge clk);
            cur_n = n;
            if (abort > 0 && n == abort + 1) begin
                chk("rst_busy", busy, 0);
                chk("rst_sel", PE_weight_partial_sel, 1);
                chk("rst_act", PE_act_in, 0);
                chk("rst_wet", PE_wet_in, 0);
                chk("rst_done", done, 0);
                chk("rst_clr", PE_clear_acc, 0);
                chk("rst_mac", PE_mac_enable, 0);
                chk("rst_ren", {wet_rd_en, act_rd_en}, 0);
                chk("rst_perf", perf_cycles, 0);
                break;
            end
            bz = (n <= last);
            p  = (n - 1) % T;
            t  = (n - 1) / T;
            pm = (n - 2) % T;
            tm = (n - 2) / T;
            pl = (n >= 2) && (n - 1 <= last) && (pm < ACCU);
            ps = (n >= 2) && (n - 1 <= last) && (pm >= ACCU) && (pm < ACCU + BN);
            e_wet = pl ? wmem[w_row_addr(wb, tm, ACCU - 1 - pm)] : '0;
            e_act = ps ? amem[a_vec_addr(ab, tm, pm - ACCU)] : '0;
            chk("busy", busy, bz);
            chk("wet_rd_en", wet_rd_en, bz && (p < ACCU));
            chk("act_rd_en", act_rd_en, bz && (p >= ACCU) && (p < ACCU + BN));
            if (bz && p < ACCU)
                chk("wet_rd_addr", wet_rd_addr, w_row_addr(wb, t, ACCU - 1 - p));
            if (bz && p >= ACCU && p < ACCU + BN)
                chk("act_rd_addr", act_rd_addr, a_vec_addr(ab, t, p - ACCU));
            chk("PE_wet_in", PE_wet_in, e_wet);
            chk("PE_act_in", PE_act_in, e_act);
            chk("sel", PE_weight_partial_sel, pl || (n == 1) || (n > last));
            chk("clear_acc", PE_clear_acc, n == 2);
            chk("mac_enable", PE_mac_enable, bz || pl || ps);
            chk("done", done, n == last + 1);
            chk("perf", perf_cycles, 32'(exp_perf(n)));
            if (n == 1)        chk("first_wet_addr", wet_rd_addr, exp_fw);
            if (n == ACCU + 1) chk("first_act_addr", act_rd_addr, exp_fa);
            if (done && done_seen < 0) done_seen = n;
            if (prev_sel && !PE_weight_partial_sel) edges++;
            prev_sel = PE_weight_partial_sel;
            if (pl)
                for (int m = 0; m < BM; m++)
                    wrow[ACCU - 1 - pm][m] = int'($signed(PE_wet_in[m*8 +: 8]));
            if (ps)
                for (int m = 0; m < BM; m++)
                    for (int r = 0; r < ACCU; r++)
                        acc[pm - ACCU][m] += longint'($signed(PE_act_in[r*8 +: 8])) * wrow[r][m];
            step();
        end
        start = 1'b0;
        if (abort > 0) begin
            step();
        end else begin
            chk("done_cycle", 64'(done_seen), 64'(exp_done));
            chk("sel_fall_edges", 64'(edges), 64'(kef));
            for (int tt = 0; tt < kef; tt++)
                for (int j = 0; j < BN; j++) begin
                    aword = amem[a_vec_addr(ab, tt, j)];
                    for (int r = 0; r < ACCU; r++) begin
                        wword = wmem[w_row_addr(wb, tt, r)];
                        for (int m = 0; m < BM; m++)
                            gold[j][m] += longint'($signed(aword[r*8 +: 8])) *
                                          longint'($signed(wword[m*8 +: 8]));
                    end
                end
            nmis = 0;
            for (int j = 0; j < BN; j++)
                for (int m = 0; m < BM; m++)
                    if (acc[j][m] != gold[j][m]) nmis++;
            chk("matmul_mismatches", 64'(nmis), 0);
        end
    endtask

    typedef struct {
        int         k;
        logic [9:0] wb;
        logic [9:0] ab;
        int         ig1;
        int         ig2;
        int         exp_done;
        logic [9:0] exp_fw;
        logic [9:0] exp_fa;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int idle_done, idle_busy;
        tbl[0] = '{k: 1, wb: 10'h010, ab: 10'h020, ig1: 0, ig2: 0,  exp_done: 21, exp_fw: 10'h014, exp_fa: 10'h020};
        tbl[1] = '{k: 1, wb: 10'h010, ab: 10'h020, ig1: 5, ig2: 21, exp_done: 21, exp_fw: 10'h014, exp_fa: 10'h020};
        tbl[2] = '{k: 0, wb: 10'h3FE, ab: 10'h3FF, ig1: 0, ig2: 0,  exp_done: 21, exp_fw: 10'h002, exp_fa: 10'h3FF};
        tbl[3] = '{k: 3, wb: 10'h100, ab: 10'h200, ig1: 0, ig2: 0,  exp_done: 61, exp_fw: 10'h104, exp_fa: 10'h200};
        tbl[4] = '{k: 2, wb: 10'h050, ab: 10'h300, ig1: 0, ig2: 0,  exp_done: 41, exp_fw: 10'h054, exp_fa: 10'h300};

        for (int i = 0; i < 1024; i++) begin
            wmem[i] = WW'({$urandom, $urandom});
            amem[i] = AW'({$urandom, $urandom});
        end
        // identity weights and ramp activations for the three-tile job
        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < ACCU; r++)
                for (int m = 0; m < BM; m++)
                    wmem[10'h100 + t * ACCU + r][m*8 +: 8] = (r == m) ? 8'd1 : 8'd0;
            for (int j = 0; j < BN; j++)
                for (int r = 0; r < ACCU; r++)
                    amem[10'h200 + t * BN + j][r*8 +: 8] = 8'(t * 20 + j * 5 + r - 30);
        end

        reset     = 1'b1;
        start     = 1'b0;
        num_tiles = '0;
        wet_base  = '0;
        act_base  = '0;
        repeat (3) step();
        @(negedge clk);
        cur_n = 0;
        chk("reset_busy", busy, 0);
        chk("reset_sel", PE_weight_partial_sel, 1);
        chk("reset_outs", {done, wet_rd_en, act_rd_en, PE_clear_acc, PE_mac_enable}, 0);
        chk("reset_perf", perf_cycles, 0);
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++)
            run_job(tbl[i].k, tbl[i].wb, tbl[i].ab, tbl[i].ig1, tbl[i].ig2, 0,
                    tbl[i].exp_done, tbl[i].exp_fw, tbl[i].exp_fa);

        // reset in cycle 8 (tile 0 STREAM) of a three-tile job
        repeat (2) step();
        run_job(3, 10'h080, 10'h180, 0, 0, 8, 0, 10'h084, 10'h180);
        idle_done = 0;
        idle_busy = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done) idle_done++;
            if (busy) idle_busy++;
            step();
        end
        cur_n = -1;
        chk("no_done_after_reset", 64'(idle_done), 0);
        chk("no_busy_after_reset", 64'(idle_busy), 0);
        run_job(1, 10'h010, 10'h020, 0, 0, 0, 21, 10'h014, 10'h020);

        for (int i = 0; i < 8; i++) begin
            int kin, kef;
            logic [9:0] wb, ab;
            kin = $urandom_range(0, 4);
            kef = (kin == 0) ? 1 : kin;
            wb  = 10'($urandom);
            ab  = 10'($urandom);
            repeat ($urandom_range(0, 3)) step();
            run_job(kin, wb, ab, $urandom_range(1, kef * T + 1), $urandom_range(1, kef * T + 1), 0,
                    kef * T + 1, 10'(int'(wb) + ACCU - 1), ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
